time_set_input: RTL and testbench

Button-side input controller for clock time setting; the producer of the time-setting digits and per-digit blink mask that the 7-segment display controller consumes. It debounces the next/increment/confirm push-buttons and runs an edit cursor over four BCD digits in HH:MM order. It enforces 24-hour limits and issues a one-cycle commit with the new time to the timekeeping block. It sits between the board buttons and both the display controller and the time counter; it is gated by the mode FSM's time-set enable.

---
 rtl/time_set_if.sv | 33 +++
 rtl/time_set_input.sv | 142 ++++++++++++++
 tb/tb_time_set_input.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/time_set_if.sv
// Button, load-digit and edited-time signals between the board/mode side and the time-set controller.
// The controller connects through the slave modport; the driving side uses master.
interface time_set_if;
    logic       enable;
    logic       btn_next;
    logic       btn_inc;
    logic       btn_confirm;
    logic [3:0] load_0;
    logic [3:0] load_1;
    logic [3:0] load_2;
    logic [3:0] load_3;
    logic [3:0] set_out_0;
    logic [3:0] set_out_1;
    logic [3:0] set_out_2;
    logic [3:0] set_out_3;
    logic [3:0] blink_state;
    logic       commit;
    logic       editing;

    modport master (
        output enable, btn_next, btn_inc, btn_confirm,
        output load_0, load_1, load_2, load_3,
        input  set_out_0, set_out_1, set_out_2, set_out_3,
        input  blink_state, commit, editing
    );

    modport slave (
        input  enable, btn_next, btn_inc, btn_confirm,
        input  load_0, load_1, load_2, load_3,
        output set_out_0, set_out_1, set_out_2, set_out_3,
        output blink_state, commit, editing
    );
endinterface

// File: rtl/time_set_input.sv
// Debounced next/inc/confirm buttons drive an HH:MM edit cursor with 24-hour limits and a one-cycle commit.
// Outputs are registered; button edges arrive ~DEBOUNCE_CYCLES+3 cycles after a stable press.
module time_set_input #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_CYCLES   = 25_000_000
) (
    input logic      clk,
    input logic      reset,
    time_set_if.slave ts
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RP_W = $clog2(REPEAT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, LOAD, EDIT} state_t;

    state_t     state;
    logic [1:0] cursor;
    logic [3:0] dig     [4];
    logic [3:0] dig_inc [4];
    logic       commit_r;
    logic       enable_d;

    // Button index: 0 = next, 1 = inc, 2 = confirm
    logic [2:0]      raw;
    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [2:0]      acc;
    logic [2:0]      acc_d;
    logic [DB_W-1:0] db_cnt [3];
    logic [2:0]      rise;
    logic [RP_W-1:0] rep_cnt;

    logic in_edit;
    logic next_p;
    logic inc_p;
    logic conf_p;

    assign raw     = {ts.btn_confirm, ts.btn_inc, ts.btn_next};
    assign in_edit = (state == EDIT);
    assign rise    = acc & ~acc_d;
    assign next_p  = rise[0];
    assign conf_p  = rise[2];
    assign inc_p   = rise[1] | (acc[1] & in_edit & (rep_cnt == RP_W'(REPEAT_CYCLES)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            acc   <= '0;
            acc_d <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            acc_d <= acc;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == acc[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    acc[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Repeat chain only starts from a fresh inc edge seen in EDIT, so a key held across entry never repeats
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_cnt <= '0;
        end else if (!acc[1] || !in_edit) begin
            rep_cnt <= '0;
        end else if (rise[1] || rep_cnt == RP_W'(REPEAT_CYCLES)) begin
            rep_cnt <= RP_W'(1);
        end else if (rep_cnt != '0) begin
            rep_cnt <= rep_cnt + 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) dig_inc[i] = dig[i];
        case (cursor)
            2'd3: begin
                dig_inc[3] = (dig[3] >= 4'd2) ? 4'd0 : dig[3] + 4'd1;
                if (dig_inc[3] == 4'd2 && dig[2] > 4'd3) dig_inc[2] = 4'd3;
            end
            2'd2: begin
                if (dig[3] == 4'd2) dig_inc[2] = (dig[2] >= 4'd3) ? 4'd0 : dig[2] + 4'd1;
                else                dig_inc[2] = (dig[2] >= 4'd9) ? 4'd0 : dig[2] + 4'd1;
            end
            2'd1:    dig_inc[1] = (dig[1] >= 4'd5) ? 4'd0 : dig[1] + 4'd1;
            default: dig_inc[0] = (dig[0] >= 4'd9) ? 4'd0 : dig[0] + 4'd1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cursor   <= 2'd3;
            commit_r <= 1'b0;
            enable_d <= 1'b0;
            for (int i = 0; i < 4; i++) dig[i] <= '0;
        end else begin
            enable_d <= ts.enable;
            commit_r <= 1'b0;
            case (state)
                IDLE: if (ts.enable && !enable_d) state <= LOAD;
                LOAD: begin
                    dig[0] <= ts.load_0;
                    dig[1] <= ts.load_1;
                    dig[2] <= ts.load_2;
                    dig[3] <= ts.load_3;
                    cursor <= 2'd3;
                    state  <= EDIT;
                end
                EDIT: begin
                    if (!ts.enable) begin
                        state <= IDLE;
                    end else if (conf_p) begin
                        commit_r <= 1'b1;
                        state    <= IDLE;
                    end else if (inc_p) begin
                        for (int i = 0; i < 4; i++) dig[i] <= dig_inc[i];
                    end else if (next_p) begin
                        cursor <= cursor - 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ts.set_out_0   = dig[0];
    assign ts.set_out_1   = dig[1];
    assign ts.set_out_2   = dig[2];
    assign ts.set_out_3   = dig[3];
    assign ts.blink_state = in_edit ? (4'b0001 << cursor) : 4'b0000;
    assign ts.commit      = commit_r;
    assign ts.editing     = in_edit;
endmodule

// File: tb/tb_time_set_input.sv
// Bench for time_set_input: directed scenarios plus random presses, checked every cycle against a behavioural model.
module tb_time_set_input;
    localparam int DB = 4;
    localparam int RP = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    time_set_if ts();

    time_set_input #(.DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RP)) dut (
        .clk  (clk),
        .reset(reset),
        .ts   (ts)
    );

    int checks = 0;
    int errors = 0;
    int commit_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] digs();
        return {ts.set_out_3, ts.set_out_2, ts.set_out_1, ts.set_out_0};
    endfunction

    // Behavioural model: button histories decide when an accepted level flips
    int m_state;            // 0 idle, 1 load, 2 edit
    int m_dig [4];
    int m_cur;
    bit m_commit;
    bit m_en_d;
    bit acc [3];
    bit accp [3];
    bit hist [3][8];        // hist[b][k] = raw level sampled k+1 edges ago
    int n;
    bit chain_on;
    int chain_start;
    bit pul [3];
    bit rawv [3];
    bit flip, rep, incp;
    int lim;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state = 0; m_cur = 3; m_commit = 0; m_en_d = 0; n = 0;
            chain_on = 0; chain_start = 0;
            for (int i = 0; i < 4; i++) m_dig[i] = 0;
            for (int b = 0; b < 3; b++) begin
                acc[b] = 0; accp[b] = 0;
                for (int k = 0; k < 8; k++) hist[b][k] = 0;
            end
        end else begin
            n++;
            rawv[0] = ts.btn_next; rawv[1] = ts.btn_inc; rawv[2] = ts.btn_confirm;
            for (int b = 0; b < 3; b++) pul[b] = acc[b] && !accp[b];
            rep  = chain_on && acc[1] && m_state == 2 && (n - chain_start) == RP;
            incp = pul[1] || rep;
            if (!acc[1] || m_state != 2) chain_on = 0;
            else if (incp) begin chain_on = 1; chain_start = n; end

            m_commit = 0;
            case (m_state)
                0: if (ts.enable && !m_en_d) m_state = 1;
                1: begin
                    m_dig[0] = ts.load_0; m_dig[1] = ts.load_1;
                    m_dig[2] = ts.load_2; m_dig[3] = ts.load_3;
                    m_cur = 3; m_state = 2;
                end
                default: begin
                    if (!ts.enable) m_state = 0;
                    else if (pul[2]) begin m_commit = 1; m_state = 0; end
                    else if (incp) begin
                        case (m_cur)
                            3: lim = 2;
                            2: lim = (m_dig[3] == 2) ? 3 : 9;
                            1: lim = 5;
                            default: lim = 9;
                        endcase
                        m_dig[m_cur] = (m_dig[m_cur] >= lim) ? 0 : m_dig[m_cur] + 1;
                        if (m_cur == 3 && m_dig[3] == 2 && m_dig[2] > 3) m_dig[2] = 3;
                    end else if (pul[0]) m_cur = (m_cur + 3) % 4;
                end
            endcase
            m_en_d = ts.enable;

            for (int b = 0; b < 3; b++) begin
                accp[b] = acc[b];
                flip = 1;
                for (int k = 1; k <= DB; k++) if (hist[b][k] == acc[b]) flip = 0;
                if (flip) acc[b] = !acc[b];
                for (int k = 7; k > 0; k--) hist[b][k] = hist[b][k-1];
                hist[b][0] = rawv[b];
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("outputs",
                {10'd0, digs(), ts.blink_state, ts.commit, ts.editing},
                {10'd0, 4'(m_dig[3]), 4'(m_dig[2]), 4'(m_dig[1]), 4'(m_dig[0]),
                 (m_state == 2) ? 4'(1 << m_cur) : 4'b0000, m_commit, m_state == 2});
            if (ts.commit) commit_seen++;
        end
    end

    task automatic wait_cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic set_btn(input logic [2:0] mask);
        ts.btn_next    = mask[0];
        ts.btn_inc     = mask[1];
        ts.btn_confirm = mask[2];
    endtask

    task automatic press(input logic [2:0] mask, input int len);
        set_btn(mask);
        wait_cyc(len);
        set_btn(3'b000);
        wait_cyc(10);
    endtask

    task automatic set_load(input logic [15:0] v);
        ts.load_3 = v[15:12]; ts.load_2 = v[11:8]; ts.load_1 = v[7:4]; ts.load_0 = v[3:0];
    endtask

    initial begin
        ts.enable = 1'b0;
        set_btn(3'b000);
        set_load(16'h1345);
        wait_cyc(3);
        chk("reset_digits", digs(), 16'h0000);
        chk("reset_blink", ts.blink_state, 4'b0000);
        chk("reset_editing", ts.editing, 1'b0);
        reset = 1'b0;
        wait_cyc(2);

        ts.enable = 1'b1;
        wait_cyc(2);
        chk("entry_digits", digs(), 16'h1345);
        chk("entry_blink", ts.blink_state, 4'b1000);
        chk("entry_editing", ts.editing, 1'b1);

        press(3'b010, 3);
        chk("glitch_ignored", digs(), 16'h1345);
        press(3'b010, 8);
        chk("hour_tens_inc_clamp", digs(), 16'h2345);

        press(3'b001, 6); chk("cursor_2", ts.blink_state, 4'b0100);
        press(3'b001, 6); chk("cursor_1", ts.blink_state, 4'b0010);
        press(3'b001, 6); chk("cursor_0", ts.blink_state, 4'b0001);
        press(3'b001, 6); chk("cursor_3", ts.blink_state, 4'b1000);

        press(3'b001, 6); press(3'b001, 6);
        press(3'b010, 6); chk("min_tens_5", digs(), 16'h2355);
        press(3'b010, 6); chk("min_tens_wrap", digs(), 16'h2305);

        press(3'b001, 6); press(3'b001, 6);
        press(3'b010, 6); press(3'b010, 6);
        chk("hour_tens_1", digs(), 16'h1305);
        press(3'b001, 6);
        for (int i = 0; i < 7; i++) press(3'b010, 6);
        chk("hour_ones_zero", digs(), 16'h1005);
        for (int i = 0; i < 9; i++) press(3'b010, 6);
        chk("hour_ones_nine", digs(), 16'h1905);
        press(3'b010, 6);
        chk("hour_ones_wrap", digs(), 16'h1005);

        press(3'b011, 6);
        chk("inc_beats_next_digits", digs(), 16'h1105);
        chk("inc_beats_next_cursor", ts.blink_state, 4'b0100);

        press(3'b010, 30);
        chk("auto_repeat", digs(), 16'h1505);

        commit_seen = 0;
        press(3'b100, 6);
        chk("commit_once", commit_seen, 1);
        chk("commit_digits", digs(), 16'h1505);
        chk("commit_blink", ts.blink_state, 4'b0000);
        chk("commit_editing", ts.editing, 1'b0);

        ts.enable = 1'b0;
        set_load(16'h2359);
        wait_cyc(2);
        ts.enable = 1'b1;
        wait_cyc(2);
        chk("reentry_digits", digs(), 16'h2359);
        commit_seen = 0;
        ts.enable = 1'b0;
        wait_cyc(3);
        chk("abort_no_commit", commit_seen, 0);
        chk("abort_blink", ts.blink_state, 4'b0000);
        chk("abort_editing", ts.editing, 1'b0);

        ts.enable = 1'b1;
        wait_cyc(3);
        chk("pre_reset_editing", ts.editing, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_digits", digs(), 16'h0000);
        chk("async_reset_blink", ts.blink_state, 4'b0000);
        chk("async_reset_editing", ts.editing, 1'b0);
        wait_cyc(2);
        reset = 1'b0;

        for (int it = 0; it < 160; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                set_load(16'($urandom));
                ts.enable = ~ts.enable;
                wait_cyc($urandom_range(1, 4));
            end else begin
                set_btn(3'($urandom_range(1, 7)));
                wait_cyc($urandom_range(1, 14));
                set_btn(3'b000);
                wait_cyc($urandom_range(0, 12));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
